// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares one instruction-memory read port between the fetch
// unit (r0) and the debug/loader port (r1).
//   im_clk, im_rst            clock, async active-low reset
//   r0_* / r1_*               request/addr in, gnt pulse out (comb), rvalid/rdata response
//   r0_flush                  drop every in-flight r0 response, block r0 grant this cycle
//   drain_req / drain_done    quiesce request / registered "drained" status
//   m_ce, m_addr, m_instr,    memory port; data returns MEM_LAT cycles after issue
//   m_valid
//   err_sticky                a response was delivered while m_valid was low
module imem_fetch_arbiter #(
   parameter int unsigned PC_WIDTH = 32,
   parameter int unsigned IWIDTH   = 32,
   parameter int unsigned MEM_LAT  = 2,
   parameter int unsigned RR_EN    = 1
) (
   input  logic                im_clk,
   input  logic                im_rst,
   input  logic                r0_req,
   input  logic [PC_WIDTH-1:0] r0_addr,
   output logic                r0_gnt,
   output logic                r0_rvalid,
   output logic [IWIDTH-1:0]   r0_rdata,
   input  logic                r0_flush,
   input  logic                r1_req,
   input  logic [PC_WIDTH-1:0] r1_addr,
   output logic                r1_gnt,
   output logic                r1_rvalid,
   output logic [IWIDTH-1:0]   r1_rdata,
   input  logic                drain_req,
   output logic                drain_done,
   output logic                m_ce,
   output logic [PC_WIDTH-1:0] m_addr,
   input  logic [IWIDTH-1:0]   m_instr,
   input  logic                m_valid,
   output logic                err_sticky
);

   localparam int unsigned TAIL = MEM_LAT - 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                run_q;
   logic                ptr_q, ptr_d;
   logic [MEM_LAT-1:0]  tag_v_q, tag_v_d, tag_id_q, tag_id_d, keep_v;
   logic                gnt_en, r0_elig, r1_elig;
   logic                tail_v, tail_id, r0_hit, r1_hit, pipe_busy;
   logic                drain_done_q, err_q;
   logic [IWIDTH-1:0]   r0_rdata_q, r1_rdata_q;

   // Grants only once out of reset for a full edge, and never while draining.
   assign gnt_en  = run_q & (state_q != ST_DRAIN) & ~drain_req;
   assign r0_elig = gnt_en & r0_req & ~r0_flush;
   assign r1_elig = gnt_en & r1_req;

   // State register.
   always_ff @(posedge im_clk or negedge im_rst) begin
      if (!im_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; drain request overrides everything.
   always_comb begin
      state_d = state_q;
      if (drain_req) begin
         state_d = ST_DRAIN;
      end else begin
         case (state_q)
            ST_IDLE:   if (m_ce) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!r0_req && !r1_req && !pipe_busy) state_d = ST_IDLE;
            ST_DRAIN:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Grant outputs: pointer breaks ties when round-robin is enabled, else r0 wins.
   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      if (r0_elig && r1_elig) begin
         if ((RR_EN != 0) && ptr_q) r1_gnt = 1'b1;
         else                       r0_gnt = 1'b1;
      end else begin
         r0_gnt = r0_elig;
         r1_gnt = r1_elig;
      end
   end

   assign m_ce   = r0_gnt | r1_gnt;
   assign m_addr = r1_gnt ? r1_addr : (r0_gnt ? r0_addr : '0);
   assign ptr_d  = r0_gnt ? 1'b1 : (r1_gnt ? 1'b0 : ptr_q);

   // Tag pipe: shift toward the tail; a flush kills every r0 entry, tail included.
   assign keep_v   = tag_v_q & ~({MEM_LAT{r0_flush}} & ~tag_id_q);
   assign tag_v_d  = MEM_LAT'({keep_v, m_ce});
   assign tag_id_d = MEM_LAT'({tag_id_q, r1_gnt});
   assign pipe_busy = |tag_v_q;

   assign tail_v  = tag_v_q[TAIL];
   assign tail_id = tag_id_q[TAIL];
   assign r0_hit  = tail_v & ~tail_id & ~r0_flush;
   assign r1_hit  = tail_v & tail_id;

   // Responses line up with m_instr in the tail cycle; rdata holds the last delivery.
   assign r0_rvalid  = r0_hit;
   assign r1_rvalid  = r1_hit;
   assign r0_rdata   = r0_hit ? m_instr : r0_rdata_q;
   assign r1_rdata   = r1_hit ? m_instr : r1_rdata_q;
   assign drain_done = drain_done_q;
   assign err_sticky = err_q;

   // Datapath and status registers.
   always_ff @(posedge im_clk or negedge im_rst) begin
      if (!im_rst) begin
         run_q        <= 1'b0;
         ptr_q        <= 1'b0;
         tag_v_q      <= '0;
         tag_id_q     <= '0;
         r0_rdata_q   <= '0;
         r1_rdata_q   <= '0;
         drain_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         run_q        <= 1'b1;
         ptr_q        <= ptr_d;
         tag_v_q      <= tag_v_d;
         tag_id_q     <= tag_id_d;
         r0_rdata_q   <= r0_rdata;
         r1_rdata_q   <= r1_rdata;
         drain_done_q <= (state_d == ST_DRAIN) & ~(|tag_v_d);
         err_q        <= err_q | ((r0_hit | r1_hit) & ~m_valid);
      end
   end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed, table-driven bench for imem_fetch_arbiter (MEM_LAT=2), with a second
// fixed-priority instance (RR_EN=0) sharing the same stimulus for grant checks.
module tb_imem_fetch_arbiter;

   logic        im_clk = 1'b0;
   logic        im_rst;
   logic        r0_req, r0_flush, r1_req, drain_req, m_valid;
   logic [31:0] r0_addr, r1_addr, m_instr;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, drain_done, m_ce, err_sticky;
   logic [31:0] r0_rdata, r1_rdata, m_addr;
   logic        fp_r0_gnt, fp_r0_rvalid, fp_r1_gnt, fp_r1_rvalid, fp_drain_done, fp_m_ce, fp_err;
   logic [31:0] fp_r0_rdata, fp_r1_rdata, fp_m_addr;

   always #5 im_clk = ~im_clk;

   imem_fetch_arbiter #(.PC_WIDTH(32), .IWIDTH(32), .MEM_LAT(2), .RR_EN(1)) dut (
      .im_clk(im_clk), .im_rst(im_rst),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
      .r0_rdata(r0_rdata), .r0_flush(r0_flush),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
      .r1_rdata(r1_rdata),
      .drain_req(drain_req), .drain_done(drain_done),
      .m_ce(m_ce), .m_addr(m_addr), .m_instr(m_instr), .m_valid(m_valid),
      .err_sticky(err_sticky));

   imem_fetch_arbiter #(.PC_WIDTH(32), .IWIDTH(32), .MEM_LAT(2), .RR_EN(0)) u_fp (
      .im_clk(im_clk), .im_rst(im_rst),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(fp_r0_gnt), .r0_rvalid(fp_r0_rvalid),
      .r0_rdata(fp_r0_rdata), .r0_flush(r0_flush),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(fp_r1_gnt), .r1_rvalid(fp_r1_rvalid),
      .r1_rdata(fp_r1_rdata),
      .drain_req(drain_req), .drain_done(fp_drain_done),
      .m_ce(fp_m_ce), .m_addr(fp_m_addr), .m_instr(m_instr), .m_valid(m_valid),
      .err_sticky(fp_err));

   // Memory model: word data = 0xD0000000 | word index, two-cycle read latency.
   logic [31:0] mp0 = 32'h0;
   logic [31:0] mp1 = 32'h0;
   always @(posedge im_clk) begin
      mp1 <= mp0;
      mp0 <= m_ce ? (32'hD000_0000 | (m_addr >> 2)) : 32'hBAD0_0000;
   end
   assign m_instr = mp1;

   localparam logic [31:0] D = 32'hD000_0000;

   typedef struct {
      logic        r0q;
      logic [31:0] a0;
      logic        fl;
      logic        r1q;
      logic [31:0] a1;
      logic        dr;
      logic        mv;
      logic [1:0]  g;
      logic [1:0]  fg;
      logic [31:0] ma;
      logic [1:0]  rv;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        dd;
      logic        er;
   } vec_t;

   vec_t vt[$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic r0q, input logic [31:0] a0, input logic fl,
                               input logic r1q, input logic [31:0] a1, input logic dr,
                               input logic mv, input logic [1:0] g, input logic [1:0] fg,
                               input logic [31:0] ma, input logic [1:0] rv,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic dd, input logic er);
      vec_t v;
      v.r0q = r0q; v.a0 = a0; v.fl = fl; v.r1q = r1q; v.a1 = a1; v.dr = dr; v.mv = mv;
      v.g = g; v.fg = fg; v.ma = ma; v.rv = rv; v.d0 = d0; v.d1 = d1; v.dd = dd; v.er = er;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
      end
   endtask

   task automatic idle_in();
      r0_req = 1'b0; r0_addr = 32'h0; r0_flush = 1'b0;
      r1_req = 1'b0; r1_addr = 32'h0; drain_req = 1'b0; m_valid = 1'b1;
   endtask

   initial begin
      // Per-cycle vectors: r0q a0 fl r1q a1 dr mv | gnt fp_gnt m_addr rvalid d0 d1 done err
      // single fetch, latency 2
      vt.push_back(mk(1'b1, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h0,   2'b00, 32'h0,  32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, 32'h0,  32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b01, D,      32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D,      32'h0,  1'b0, 1'b0));
      // streaming 0x0..0xC
      vt.push_back(mk(1'b1, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h0,   2'b00, D,      32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h4,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h4,   2'b00, D,      32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h8,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h8,   2'b01, D,      32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'hC,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'hC,   2'b01, D|32'h1,32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b01, D|32'h2,32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b01, D|32'h3,32'h0,  1'b0, 1'b0));
      // lone r1 moves pointer back to r0, then 6 cycles of contention
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 2'b10, 2'b10, 32'h100, 2'b00, D|32'h3,32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 2'b01, 2'b01, 32'h10,  2'b00, D|32'h3,32'h0,  1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 2'b10, 2'b01, 32'h104, 2'b10, D|32'h3,D|32'h40,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 2'b01, 2'b01, 32'h10,  2'b01, D|32'h4,D|32'h40,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 2'b10, 2'b01, 32'h104, 2'b10, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 2'b01, 2'b01, 32'h10,  2'b01, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 2'b10, 2'b01, 32'h104, 2'b10, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b01, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b10, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'h4,D|32'h41,1'b0, 1'b0));
      // flush with two r0 in flight while r1 is granted
      vt.push_back(mk(1'b1, 32'h20, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h20,  2'b00, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h24, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h24,  2'b00, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h24, 1'b1, 1'b1, 32'h108, 1'b0, 1'b1, 2'b10, 2'b10, 32'h108, 2'b00, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'h4,D|32'h41,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b10, D|32'h4,D|32'h42,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'h4,D|32'h42,1'b0, 1'b0));
      // drain with two in flight, then release with r1 pending
      vt.push_back(mk(1'b1, 32'h30, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h30,  2'b00, D|32'h4,D|32'h42,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h10C, 1'b0, 1'b1, 2'b10, 2'b10, 32'h10C, 2'b00, D|32'h4,D|32'h42,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h34, 1'b0, 1'b1, 32'h110, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0,   2'b01, D|32'hC,D|32'h42,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h34, 1'b0, 1'b1, 32'h110, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0,   2'b10, D|32'hC,D|32'h43,1'b0, 1'b0));
      vt.push_back(mk(1'b1, 32'h34, 1'b0, 1'b1, 32'h110, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'hC,D|32'h43,1'b1, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h110, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'hC,D|32'h43,1'b1, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h110, 1'b0, 1'b1, 2'b10, 2'b10, 32'h110, 2'b00, D|32'hC,D|32'h43,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'hC,D|32'h43,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b10, D|32'hC,D|32'h44,1'b0, 1'b0));
      // memory not valid at the tail -> still delivered, error latched
      vt.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b01, 2'b01, 32'h40,  2'b00, D|32'hC,D|32'h44,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'hC,D|32'h44,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 2'b00, 2'b00, 32'h0,   2'b01, D|32'h10,D|32'h44,1'b0, 1'b0));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'h10,D|32'h44,1'b0, 1'b1));
      vt.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 2'b00, 2'b00, 32'h0,   2'b00, D|32'h10,D|32'h44,1'b0, 1'b1));

      // Reset held with a pending fetch: nothing may come out.
      im_rst = 1'b0;
      idle_in();
      r0_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge im_clk); #1;
         chk("rst_ctl", i, {25'h0, r0_gnt, r1_gnt, m_ce, r0_rvalid, r1_rvalid, drain_done, err_sticky}, 32'h0);
         chk("rst_rdata", i, r0_rdata | r1_rdata, 32'h0);
      end
      @(negedge im_clk);
      im_rst = 1'b1;
      #1;
      chk("release_gnt", 0, {30'h0, r1_gnt, r0_gnt}, 32'h0);

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge im_clk);
         r0_req = vt[i].r0q; r0_addr = vt[i].a0; r0_flush = vt[i].fl;
         r1_req = vt[i].r1q; r1_addr = vt[i].a1; drain_req = vt[i].dr; m_valid = vt[i].mv;
         #1;
         chk("gnt", i, {30'h0, r1_gnt, r0_gnt}, {30'h0, vt[i].g});
         chk("fp_gnt", i, {30'h0, fp_r1_gnt, fp_r0_gnt}, {30'h0, vt[i].fg});
         chk("m_ce", i, {31'h0, m_ce}, {31'h0, |vt[i].g});
         if (vt[i].g != 2'b00) chk("m_addr", i, m_addr, vt[i].ma);
         chk("rvalid", i, {30'h0, r1_rvalid, r0_rvalid}, {30'h0, vt[i].rv});
         chk("r0_rdata", i, r0_rdata, vt[i].d0);
         chk("r1_rdata", i, r1_rdata, vt[i].d1);
         chk("drain_done", i, {31'h0, drain_done}, {31'h0, vt[i].dd});
         chk("err_sticky", i, {31'h0, err_sticky}, {31'h0, vt[i].er});
      end

      // Reset mid-flight: granted fetch must never come back.
      @(negedge im_clk);
      idle_in(); r0_req = 1'b1; r0_addr = 32'h50;
      #1; chk("mid_gnt", 0, {31'h0, r0_gnt}, 32'h1);
      @(negedge im_clk);
      r0_req = 1'b0; im_rst = 1'b0;
      #1; chk("mid_rst_ctl", 0, {26'h0, r0_gnt, m_ce, r0_rvalid, r1_rvalid, drain_done, err_sticky}, 32'h0);
      chk("mid_rst_rdata", 0, r0_rdata, 32'h0);
      @(negedge im_clk); #1;
      chk("mid_rst_rvalid", 1, {31'h0, r0_rvalid}, 32'h0);
      @(negedge im_clk);
      im_rst = 1'b1;
      #1; chk("post_rst_rvalid", 0, {31'h0, r0_rvalid}, 32'h0);
      for (int i = 1; i < 4; i++) begin
         @(negedge im_clk); #1;
         chk("post_rst_rvalid", i, {31'h0, r0_rvalid}, 32'h0);
         chk("post_rst_rdata", i, r0_rdata, 32'h0);
      end
      @(negedge im_clk);
      r0_req = 1'b1; r0_addr = 32'h50;
      #1; chk("post_rst_gnt", 0, {31'h0, r0_gnt}, 32'h1);
      @(negedge im_clk);
      r0_req = 1'b0;
      #1; chk("post_rst_wait", 0, {31'h0, r0_rvalid}, 32'h0);
      @(negedge im_clk); #1;
      chk("post_rst_resp", 0, {31'h0, r0_rvalid}, 32'h1);
      chk("post_rst_data", 0, r0_rdata, D | 32'h14);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
